// File: rtl/cpu_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// the packed control word, and its canonical values.
package cpu_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_hold;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN      = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                           id_ex_bubble: 1'b0, pipe_hold: 1'b0};
  localparam pipe_ctrl_t CTRL_HOLD     = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                           id_ex_bubble: 1'b0, pipe_hold: 1'b1};
  localparam pipe_ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                           id_ex_bubble: 1'b1, pipe_hold: 1'b0};
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                           id_ex_bubble: 1'b1, pipe_hold: 1'b0};
  localparam pipe_ctrl_t CTRL_RESET    = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                           id_ex_bubble: 1'b1, pipe_hold: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read
// by the instruction in ID. x0 never creates a dependency.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/bubble generation, data-memory wait
// watchdog, and optional performance counters (enabled by PIPE_CTRL_PERF_EN).
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count,
  output pipe_ctrl_state_t state_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  pipe_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  pipe_ctrl_t       ctrl;
  logic             load_use;
  logic             mem_stall;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // Handshake: a MEM-stage access completes in the cycle mem_req && mem_ready;
  // mem_req with mem_ready low means the stage must be frozen this cycle.
  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    ctrl       = CTRL_RUN;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          ctrl = CTRL_HOLD;
          if (state_q == RUN) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = CNT_W'(1);
          end else begin
            if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == CNT_LIMIT)) state_d = ERR;
            if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
          if (ex_branch_taken) ctrl = CTRL_REDIRECT;
          else if (load_use)   ctrl = CTRL_LOAD_USE;
        end
      end
      default: begin
        ctrl    = CTRL_HOLD;
        state_d = ERR;
      end
    endcase
    // Reset drives the pipeline to a flushed, frozen-PC state asynchronously.
    if (!rst_n) ctrl = CTRL_RESET;
  end

  assign mem_timeout_d = mem_timeout_q || (state_d == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign pipe_hold    = ctrl.pipe_hold;
  assign mem_timeout  = mem_timeout_q;
  assign state_o      = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!ctrl.pc_write && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (ctrl.if_id_flush && (flush_count_q != 32'hFFFF_FFFF))
      flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
